scan_seq_4x16: RTL and testbench
================================

Name: scan_seq_4x16

Overview:
- Sequential scan controller sitting directly upstream of the 4x16 decoder; drives the decoder's en and 4-bit in.
- Steps through the 16 decoder channels in ascending order, skipping masked-off channels, and holds each for a programmable dwell time.
- Supports single-pass and continuous modes. Typical uses: LED/keypad row scanning and test sequencing.

Parameters:
- DWELL_W, 8, width of the dwell count; each channel is held for dwell+1 cycles.
- NCH, 16, number of channels (fixed at 16 to match the 4-bit decoder select; not user-overridable).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a scan (level sampled each cycle; only acted on in IDLE).
- stop  in  1  abort the scan; return to IDLE.
- mode_cont  in  1  1 = continuous (wrap forever), 0 = single pass; sampled at start.
- dwell  in  DWELL_W  hold cycles minus one; sampled at start.
- mask  in  16  channel enable mask; bit k=1 means channel k is visited; sampled at start.
- sel_en  out  1  decoder enable.
- sel_in  out  4  decoder channel select.
- busy  out  1  high while a scan is in progress.
- done  out  1  one-cycle pulse when a single pass completes.

Behaviour:
- Reset values: sel_en=0, sel_in=0, busy=0, done=0; FSM=IDLE; internal mode, dwell and mask latches cleared.
- Reset is asynchronous and takes effect mid-scan. Outputs drop immediately; no done pulse.
- All outputs are registered.
- FSM states: IDLE, HOLD, FINISH.
- IDLE, start=1 and mask!=0:
  - Latch mode_cont, dwell and mask.
  - Next cycle: sel_in = lowest set mask bit, sel_en=1, busy=1, dwell counter=0, state HOLD.
  - Latency from start to sel_en is 1 cycle.
- IDLE, start=1 and mask==0: no scan; done pulses for 1 cycle; busy stays 0.
- HOLD:
  - The dwell counter increments each cycle.
  - When counter==dwell_latched, advance to the next set mask bit above sel_in and reset the counter.
  - Wrap-around, next channel search, continuous mode: search past 15 wraps to 0. Single set bit means the same channel is re-held with no gap.
  - Wrap-around, single-pass mode: no set bit above sel_in means state FINISH.
- FINISH: sel_en=0, busy=0, done=1 for exactly one cycle, then IDLE. sel_in keeps its last value.
- stop=1 in HOLD: next cycle sel_en=0, busy=0, state IDLE; no done pulse.
- stop and start both high in the same cycle: stop wins.
- start while busy: ignored.
- Input changes while busy: mask, dwell and mode_cont changes are ignored until the next start.
- Channel dwell: each visited channel asserts sel_en with a stable sel_in for exactly dwell+1 consecutive cycles. Between channels there is no idle cycle.

Optional Feature:
- Macro SCAN_PAUSE_EN.
- Defined:
  - Adds input port pause (1 bit).
  - While pause=1 in HOLD, the dwell counter freezes and sel_en/sel_in stay unchanged.
  - stop still overrides pause.
- Undefined: no pause port; the dwell counter always runs.

Decomposition:
- Package scan_seq_pkg holds:
  - state encoding localparams: IDLE=2'd0, HOLD=2'd1, FINISH=2'd2;
  - NCH=16 and SEL_W=4.
- One sub-module, next_chan_find. It is combinational:
  - Inputs: mask[15:0], cur[3:0], wrap.
  - Outputs: nxt[3:0] and found. found=0 means no set bit above cur while wrap=0.
  - It is also used with cur treated as -1 for the first-channel search.

Test Plan:
- Reset mid-scan: start with mask=16'hFFFF and dwell=2. Assert rst_n=0 in cycle 5. Required: sel_en, busy and done go to 0 asynchronously; no done pulse after release.
- Single pass, full mask: mask=16'hFFFF, dwell=0, mode_cont=0, start pulse. Required: sel_in = 0..15, one cycle each, sel_en high for 16 cycles. Then done pulses once and busy falls in the same cycle.
- Sparse mask with dwell: mask=16'h8421, dwell=3, mode_cont=0. Required: sel_in = 0, 5, 10, 15 (mask bits 0, 5, 10 and 15), each held for 4 cycles, then done.
- Continuous wrap and stop: mask=16'h0006, dwell=1, mode_cont=1. Required: sel_in = 1,1,2,2,1,1,2,2,... After 10 cycles assert stop. Required: the next cycle sel_en=0 and busy=0, with no done pulse.
- Empty mask: mask=0, start. Required: done=1 for 1 cycle; busy and sel_en stay 0.
- Collisions: start and stop asserted together in IDLE, then start asserted while busy. Required: the start+stop cycle leaves the FSM in IDLE; the start while busy does not restart the scan (sel_in sequence continues unchanged).

Source files
------------

// File: rtl/scan_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scan_seq_pkg
// Description : Shared constants and FSM state encoding for the 4x16 scan
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package scan_seq_pkg;

    localparam int NCH   = 16;
    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/scan_seq_4x16_next_chan_find.sv
`default_nettype none
// ============================================================================
// Module      : next_chan_find
// Description : Combinational search for the next set mask bit above cur,
//               optionally wrapping around (cur itself is the last candidate).
// Revision    : 1.0 - initial release
// ============================================================================
module next_chan_find
    import scan_seq_pkg::*;
(
    input  logic [NCH-1:0]   mask,
    input  logic [SEL_W-1:0] cur,
    input  logic             wrap,
    output logic [SEL_W-1:0] nxt,
    output logic             found
);

    logic [SEL_W:0] w_pos;

    // Walk offsets from farthest to nearest so the nearest hit wins; offset
    // NCH lands back on cur with the carry bit set, so it only counts when wrapping.
    always_comb begin
        nxt   = '0;
        found = 1'b0;
        w_pos = '0;
        for (int i = NCH; i >= 1; i--) begin
            w_pos = {1'b0, cur} + (SEL_W+1)'(i);
            if ((wrap || !w_pos[SEL_W]) && mask[w_pos[SEL_W-1:0]]) begin
                nxt   = w_pos[SEL_W-1:0];
                found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/scan_seq_4x16.sv
`default_nettype none
// ============================================================================
// Module      : scan_seq_4x16
// Description : Scan controller driving a 4x16 decoder; visits masked-in
//               channels in ascending order, dwell+1 cycles each, single-pass
//               or continuous. Optional macro SCAN_PAUSE_EN adds a pause input.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_seq_4x16
    import scan_seq_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode_cont,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [NCH-1:0]     mask,
`ifdef SCAN_PAUSE_EN
    input  logic               pause,
`endif
    output logic               sel_en,
    output logic [SEL_W-1:0]   sel_in,
    output logic               busy,
    output logic               done
);

    state_t             r_state;
    logic               r_mode;
    logic [DWELL_W-1:0] r_dwell;
    logic [NCH-1:0]     r_mask;
    logic [DWELL_W-1:0] r_cnt;

    state_t             w_state_nxt;
    logic               w_mode_nxt;
    logic [DWELL_W-1:0] w_dwell_nxt;
    logic [NCH-1:0]     w_mask_nxt;
    logic [DWELL_W-1:0] w_cnt_nxt;
    logic               w_sel_en_nxt;
    logic [SEL_W-1:0]   w_sel_in_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;

    logic [SEL_W-1:0]   w_first;
    logic               w_first_found;
    logic [SEL_W-1:0]   w_next;
    logic               w_next_found;
    logic               w_pause;

`ifdef SCAN_PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    // First channel: searching above 15 with wrap gives the lowest set bit.
    next_chan_find u_first_find (
        .mask  (mask),
        .cur   ({SEL_W{1'b1}}),
        .wrap  (1'b1),
        .nxt   (w_first),
        .found (w_first_found)
    );

    next_chan_find u_next_find (
        .mask  (r_mask),
        .cur   (sel_in),
        .wrap  (r_mode),
        .nxt   (w_next),
        .found (w_next_found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_mode  <= 1'b0;
            r_dwell <= '0;
            r_mask  <= '0;
            r_cnt   <= '0;
            sel_en  <= 1'b0;
            sel_in  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_dwell <= w_dwell_nxt;
            r_mask  <= w_mask_nxt;
            r_cnt   <= w_cnt_nxt;
            sel_en  <= w_sel_en_nxt;
            sel_in  <= w_sel_in_nxt;
            busy    <= w_busy_nxt;
            done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_mode_nxt   = r_mode;
        w_dwell_nxt  = r_dwell;
        w_mask_nxt   = r_mask;
        w_cnt_nxt    = r_cnt;
        w_sel_en_nxt = sel_en;
        w_sel_in_nxt = sel_in;
        w_busy_nxt   = busy;
        w_done_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
                if (start && !stop) begin
                    if (w_first_found) begin
                        w_mode_nxt   = mode_cont;
                        w_dwell_nxt  = dwell;
                        w_mask_nxt   = mask;
                        w_cnt_nxt    = '0;
                        w_sel_en_nxt = 1'b1;
                        w_sel_in_nxt = w_first;
                        w_busy_nxt   = 1'b1;
                        w_state_nxt  = HOLD;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (stop) begin
                    w_sel_en_nxt = 1'b0;
                    w_busy_nxt   = 1'b0;
                    w_state_nxt  = IDLE;
                end else if (!w_pause) begin
                    if (r_cnt == r_dwell) begin
                        w_cnt_nxt = '0;
                        if (w_next_found) begin
                            w_sel_in_nxt = w_next;
                        end else begin
                            // sel_in intentionally keeps the last visited channel
                            w_sel_en_nxt = 1'b0;
                            w_busy_nxt   = 1'b0;
                            w_done_nxt   = 1'b1;
                            w_state_nxt  = FINISH;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + DWELL_W'(1);
                    end
                end
            end
            FINISH: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt  = IDLE;
                w_sel_en_nxt = 1'b0;
                w_busy_nxt   = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_scan_seq_4x16.sv
`default_nettype none
// ============================================================================
// Module      : tb_scan_seq_4x16
// Description : Directed self-checking bench for scan_seq_4x16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_seq_4x16;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        mode_cont;
    logic [7:0]  dwell;
    logic [15:0] mask;
`ifdef SCAN_PAUSE_EN
    logic        pause;
`endif
    logic        sel_en;
    logic [3:0]  sel_in;
    logic        busy;
    logic        done;

    int checks;
    int failures;

    scan_seq_4x16 #(.DWELL_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .mode_cont (mode_cont),
        .dwell     (dwell),
        .mask      (mask),
`ifdef SCAN_PAUSE_EN
        .pause     (pause),
`endif
        .sel_en    (sel_en),
        .sel_in    (sel_in),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode_cont = 1'b0;
        dwell = 8'd0; mask = 16'h0000;
`ifdef SCAN_PAUSE_EN
        pause = 1'b0;
`endif
        #12;
        checks++;
        if (sel_en !== 1'b0 || sel_in !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_state sel_en=%b sel_in=%0d busy=%b done=%b want all 0",
                     sel_en, sel_in, busy, done);
        end
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (sel_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset sel_en=%b busy=%b done=%b want 0", sel_en, busy, done);
        end
    endtask

    task automatic test_full_pass();
        mask = 16'hFFFF; dwell = 8'd0; mode_cont = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (sel_en !== 1'b1 || sel_in !== 4'(k) || busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL full_pass k=%0d sel_en=%b sel_in=%0d busy=%b done=%b want sel_in=%0d",
                         k, sel_en, sel_in, busy, done, k);
            end
            step();
        end
        checks++;
        if (sel_en !== 1'b0 || busy !== 1'b0 || done !== 1'b1 || sel_in !== 4'd15) begin
            failures++;
            $display("FAIL full_pass_done sel_en=%b busy=%b done=%b sel_in=%0d want 0/0/1/15",
                     sel_en, busy, done, sel_in);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL full_pass_done_width done=%b busy=%b want 0/0", done, busy);
        end
    endtask

    task automatic test_sparse_dwell();
        logic [3:0] chans [4];
        chans[0] = 4'd0; chans[1] = 4'd5; chans[2] = 4'd10; chans[3] = 4'd15;
        mask = 16'h8421; dwell = 8'd3; mode_cont = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        // Latched copies must be used: scribble the live inputs.
        mask = 16'h0002; dwell = 8'd0; mode_cont = 1'b1;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (sel_en !== 1'b1 || sel_in !== chans[k/4] || done !== 1'b0) begin
                failures++;
                $display("FAIL sparse k=%0d sel_en=%b sel_in=%0d done=%b want sel_in=%0d",
                         k, sel_en, sel_in, done, chans[k/4]);
            end
            step();
        end
        checks++;
        if (done !== 1'b1 || sel_en !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL sparse_done done=%b sel_en=%b busy=%b want 1/0/0", done, sel_en, busy);
        end
        step();
    endtask

    task automatic test_cont_stop();
        mask = 16'h0006; dwell = 8'd1; mode_cont = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        mode_cont = 1'b0;
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (sel_en !== 1'b1 || sel_in !== (((k / 2) % 2 == 0) ? 4'd1 : 4'd2) || done !== 1'b0) begin
                failures++;
                $display("FAIL cont k=%0d sel_en=%b sel_in=%0d done=%b want sel_in=%0d",
                         k, sel_en, sel_in, done, ((k / 2) % 2 == 0) ? 1 : 2);
            end
            step();
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if (sel_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL cont_stop sel_en=%b busy=%b done=%b want 0/0/0", sel_en, busy, done);
        end
        step();
        checks++;
        if (done !== 1'b0 || sel_en !== 1'b0) begin
            failures++;
            $display("FAIL cont_stop_nodone done=%b sel_en=%b want 0/0", done, sel_en);
        end
    endtask

    task automatic test_empty_mask();
        mask = 16'h0000; dwell = 8'd2; mode_cont = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || sel_en !== 1'b0) begin
            failures++;
            $display("FAIL empty_mask done=%b busy=%b sel_en=%b want 1/0/0", done, busy, sel_en);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || sel_en !== 1'b0) begin
            failures++;
            $display("FAIL empty_mask_after done=%b busy=%b sel_en=%b want 0/0/0", done, busy, sel_en);
        end
    endtask

    task automatic test_collisions();
        mask = 16'hFFFF; dwell = 8'd1; mode_cont = 1'b0; start = 1'b1; stop = 1'b1;
        step();
        stop = 1'b0; start = 1'b0;
        checks++;
        if (sel_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL start_stop sel_en=%b busy=%b done=%b want 0/0/0", sel_en, busy, done);
        end
        start = 1'b1;
        step();
        // Hold start high and change settings; the scan must continue untouched.
        mask = 16'h0001; dwell = 8'd5; mode_cont = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (sel_en !== 1'b1 || busy !== 1'b1 || sel_in !== 4'(k / 2)) begin
                failures++;
                $display("FAIL start_busy k=%0d sel_en=%b busy=%b sel_in=%0d want sel_in=%0d",
                         k, sel_en, busy, sel_in, k / 2);
            end
            step();
        end
        start = 1'b0; stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if (sel_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL collision_stop sel_en=%b busy=%b done=%b want 0/0/0", sel_en, busy, done);
        end
        step();
    endtask

    task automatic test_reset_mid_scan();
        mask = 16'hFFFF; dwell = 8'd2; mode_cont = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (sel_en !== 1'b1 || sel_in !== 4'(k / 3)) begin
                failures++;
                $display("FAIL pre_reset k=%0d sel_en=%b sel_in=%0d want 1/%0d", k, sel_en, sel_in, k / 3);
            end
            if (k < 4) step();
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (sel_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || sel_in !== 4'd0) begin
            failures++;
            $display("FAIL async_reset sel_en=%b busy=%b done=%b sel_in=%0d want all 0",
                     sel_en, busy, done, sel_in);
        end
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (done !== 1'b0 || sel_en !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL post_reset k=%0d done=%b sel_en=%b busy=%b want 0/0/0",
                         k, done, sel_en, busy);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_full_pass();
        test_sparse_dwell();
        test_cont_stop();
        test_empty_mask();
        test_collisions();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
